d_mem_access: RTL
=================

# d_mem_access

Load/store access unit between the RV32I datapath's memory stage and the data cache. It accepts one load or store request at a time with a raw byte address and funct3, and drives a word-aligned cache request with byte enables and lane-shifted store data. It holds that cache request until `d_mem_resp`, then returns load data extracted and sign/zero-extended to 32 bits through a one-cycle response pulse. It also detects misaligned and illegal accesses and aborts hung accesses on a timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: number of ACCESS-state cycles before abort; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
- req_addr  input  32  raw byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_error  output  1  qualifies rsp_valid: misaligned, illegal funct3, or timeout
- d_mem_read  output  1  cache read strobe
- d_mem_write  output  1  cache write strobe
- d_mem_address  output  32  `{addr[31:2], 2'b00}`
- d_mem_byte_en  output  4  lane enables
- d_mem_wdata  output  32  lane-aligned store data
- d_mem_resp  input  1  cache completion
- d_mem_rdata  input  32  cache read word

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields.
  - Illegal funct3 (011, 110, 111, or a store with 100/101): go to RESP with error.
  - Misaligned access (see Configuration): go to RESP with error.
  - Otherwise go to ACCESS.
- ACCESS: exactly one of d_mem_read or d_mem_write is 1.
  - Address, byte_en and wdata are held stable until d_mem_resp.
  - On d_mem_resp, register the extracted rdata and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_error are valid only while rsp_valid=1.
- Lane offset: off = addr[1:0].
- Byte enables and store data by size:
  - Byte: byte_en = 0001<<off; wdata = wdata[7:0]<<(8*off).
  - Half: byte_en = 0011<<(2*addr[1]); wdata = wdata[15:0]<<(16*addr[1]).
  - Word: byte_en = 1111; wdata = wdata.
- Loads drive the same byte_en. Extraction takes the selected lane, then extends it:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
- d_mem_resp in IDLE or RESP is ignored.
- Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle without resp.
  - At TIMEOUT_CYCLES: drop strobes, go to RESP with rsp_error=1, rsp_rdata=0.
  - A d_mem_resp arriving in the same cycle as the timeout wins and completes normally.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, d_mem_read=0, d_mem_write=0, d_mem_address=0, d_mem_byte_en=0, d_mem_wdata=0.
- Reset asserted mid-ACCESS clears strobes asynchronously; the in-flight response is discarded.
- All outputs are registered or decoded from registered state and latched fields. No combinational path from req_* or d_mem_* to any output.
- Request accepted at edge N: strobe high from cycle N+1.
- d_mem_resp sampled high at edge M: strobe low from M+1, rsp_valid high in cycle M+1, back in IDLE at M+2.
- Minimum accept-to-rsp_valid latency is 2 cycles; error path is 1 cycle (rsp_valid in N+1).
- Throughput: one request per 3 cycles at best. req_ready is low from N+1 until IDLE is re-entered.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is not issued to the cache.
  - Responds with rsp_error=1 one cycle after accept.
- MISALIGN_TRAP_EN undefined:
  - No misalignment check; rsp_error never set for alignment.
  - Half ignores addr[0]; word ignores addr[1:0]. The access is issued on the truncated lane.

## Test plan
- Store byte: SB addr 0x1003, wdata 0x000000A5 -> d_mem_write=1, address 0x1000, byte_en 1000, wdata 0xA5000000; resp after 3 cycles -> rsp_valid=1, rsp_error=0.
- Loads: LB then LBU at 0x2002, d_mem_rdata 0x12F43456 -> rsp_rdata 0xFFFFFFF4 then 0x000000F4. LHU at 0x2002 -> 0x000012F4.
- Misaligned: LW at 0x3001 with MISALIGN_TRAP_EN -> no strobe, rsp_valid+rsp_error in cycle N+1. Without the macro -> read at 0x3000, byte_en 1111, no error.
- Timeout: TIMEOUT_CYCLES=4, LW, d_mem_resp held 0 -> strobe drops after 4 ACCESS cycles, rsp_error=1, rsp_rdata=0. Repeat with resp in cycle 4 -> normal completion.
- Reset mid-access: rst low during ACCESS of SW -> d_mem_write=0 immediately, req_ready=1, no rsp_valid. A late d_mem_resp after release is ignored.
- Illegal funct3: store with funct3=100 -> no strobe, rsp_error=1.

Source files
------------

// File: rtl/d_mem_access.sv
// d_mem_access: RV32I load/store unit that drives a word-aligned data-cache port.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating them.
module d_mem_access #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        d_mem_read,
    output logic        d_mem_write,
    output logic [31:0] d_mem_address,
    output logic [3:0]  d_mem_byte_en,
    output logic [31:0] d_mem_wdata,
    input  logic        d_mem_resp,
    input  logic [31:0] d_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    state_t      state, state_nx;
    logic        write_q, err_q, illegal, misalign, timeout, accept;
    logic [2:0]  f3_q;
    logic [1:0]  off, off_q;
    logic [3:0]  be;
    logic [31:0] wd, lane, ext, rdata_q, cnt;
    assign accept  = state == IDLE && req_valid;
    assign illegal = req_funct3[1:0] == 2'b11 || (req_funct3[2] && (req_write || req_funct3[1]));
`ifdef MISALIGN_TRAP_EN
    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    // Halves and words drop the low address bits, so the lane is always naturally aligned.
    assign off  = req_funct3[1] ? 2'b00 : req_funct3[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
    assign be   = (req_funct3[1] ? 4'b1111 : req_funct3[0] ? 4'b0011 : 4'b0001) << off;
    assign wd   = (req_funct3[1] ? req_wdata : req_funct3[0] ? {16'b0, req_wdata[15:0]} :
                  {24'b0, req_wdata[7:0]}) << {off, 3'b000};
    assign lane = d_mem_rdata >> {off_q, 3'b000};
    assign ext  = f3_q[1] ? lane :
                  f3_q[0] ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} :
                            {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
    assign timeout = TIMEOUT_CYCLES != 0 && cnt == TO_LAST;
    always_comb begin
        state_nx = state == IDLE   ? (req_valid ? ((illegal || misalign) ? RESP : ACCESS) : IDLE) :
                   state == ACCESS ? ((d_mem_resp || timeout) ? RESP : ACCESS) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            write_q       <= 1'b0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            err_q         <= 1'b0;
            rdata_q       <= 32'b0;
            cnt           <= 32'b0;
            d_mem_address <= 32'b0;
            d_mem_byte_en <= 4'b0;
            d_mem_wdata   <= 32'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                write_q       <= req_write;
                f3_q          <= req_funct3;
                off_q         <= off;
                err_q         <= illegal || misalign;
                rdata_q       <= 32'b0;
                cnt           <= 32'b0;
                d_mem_address <= {req_addr[31:2], 2'b00};
                d_mem_byte_en <= be;
                d_mem_wdata   <= wd;
            end
            if (state == ACCESS) begin
                cnt <= cnt + 32'd1;
                if (d_mem_resp) begin
                    rdata_q <= write_q ? 32'b0 : ext;
                    err_q   <= 1'b0;
                end else if (timeout) begin
                    rdata_q <= 32'b0;
                    err_q   <= 1'b1;
                end
            end
        end
    end
    assign req_ready   = state == IDLE;
    assign rsp_valid   = state == RESP;
    assign rsp_error   = rsp_valid & err_q;
    assign rsp_rdata   = rsp_valid ? rdata_q : 32'b0;
    assign d_mem_read  = state == ACCESS && !write_q;
    assign d_mem_write = state == ACCESS && write_q;
endmodule
